dmem_responder: RTL and testbench

Memory-side responder for the pipelined CPU's data path and the upcoming cache fill logic. It accepts single-word read/write requests and 8-word burst reads over a valid/ready request channel and returns read data after a fixed access latency on a response channel that cannot be stalled. It replaces the single-cycle data memory model so the CPU and cache controllers can be exercised against realistic multi-cycle memory timing.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, XFER} state_e;

   localparam int DMEM_LATENCY   = 4;
   localparam int DMEM_BURST_LEN = 8;

   // Clear the in-block offset bits of a 15-bit word index.
   function automatic logic [14:0] block_align(input logic [14:0] widx, input int blen);
      return widx & ~15'(blen - 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read, contents not reset.
module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder: posted writes, single and burst reads with
// an unstallable response channel.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH     = 1024,
   parameter int LATENCY   = DMEM_LATENCY,
   parameter int BURST_LEN = DMEM_BURST_LEN
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic        req_burst,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_last,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(BURST_LEN);
   localparam int CW = BW + 1;

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   beats_q, beats_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [15:0]     rsp_data_q;
   logic [15:0]     rd_data;
   logic [14:0]     widx, widx_blk;
   logic            accept, wr_en;
   logic            unused_bits;

   assign widx        = req_addr[15:1];
   assign widx_blk    = block_align(widx, BURST_LEN);
   assign accept      = req_valid & req_ready;
   assign wr_en       = accept & req_wr;
   assign unused_bits = ^{req_addr[0], widx[14:AW], widx_blk[14:AW]};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      beats_d = beats_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept && !req_wr) begin
               if (req_burst) begin
                  idx_d   = widx_blk[AW-1:0];
                  beats_d = CW'(BURST_LEN);
               end else begin
                  idx_d   = widx[AW-1:0];
                  beats_d = CW'(1);
               end
               if (LATENCY == 1) begin
                  state_d = XFER;
               end else begin
                  state_d = WAIT;
                  wcnt_d  = 4'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (wcnt_q == 4'd0) state_d = XFER;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         XFER: begin
            if (beats_q == CW'(1)) begin
               state_d = IDLE;
            end else begin
               // Advance within the block only; the block base bits stay put.
               idx_d   = {idx_q[AW-1:BW], idx_q[BW-1:0] + BW'(1)};
               beats_d = beats_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read port addresses the beat that will be presented next cycle, so the
   // response data can be registered on the same edge that enters/stays in XFER.
   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk   (clk),
      .we    (wr_en),
      .waddr (widx[AW-1:0]),
      .wdata (req_wdata),
      .raddr (idx_d),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         beats_q    <= '0;
         wcnt_q     <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         beats_q <= beats_d;
         wcnt_q  <= wcnt_d;
         if (state_d == XFER) rsp_data_q <= rd_data;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == XFER);
   assign rsp_last  = (state_q == XFER) && (beats_q == CW'(1));
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder (default and LATENCY=1 builds).
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 4;
   localparam int BL    = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic        req_valid = 1'b0, req_wr = 1'b0, req_burst = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_last, busy;
   logic [15:0] rsp_data;

   logic        l1_valid = 1'b0, l1_wr = 1'b0, l1_burst = 1'b0;
   logic [15:0] l1_addr = '0, l1_wdata = '0;
   logic        l1_ready, l1_rvalid, l1_rlast, l1_busy;
   logic [15:0] l1_rdata;

   int total = 0;
   int bad   = 0;
   logic [15:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BURST_LEN(BL)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .req_valid(l1_valid), .req_ready(l1_ready),
      .req_wr(l1_wr), .req_burst(l1_burst), .req_addr(l1_addr), .req_wdata(l1_wdata),
      .rsp_valid(l1_rvalid), .rsp_data(l1_rdata), .rsp_last(l1_rlast), .busy(l1_busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int word_of(input logic [15:0] addr);
      return (int'(addr) / 2) % DEPTH;
   endfunction

   task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data;
      req_burst = 1'($urandom_range(0, 1));
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b want 1", req_ready); end
      tick;
      req_valid = 1'b0; req_wr = 1'b0;
      mem_m[word_of(addr)] = data;
      total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL wr_no_rsp: valid=%b busy=%b want 0 0", rsp_valid, busy);
      end
   endtask

   // Issue one read and check every cycle until the responder is idle again.
   // Optionally keep req_valid high with a write queued behind the read.
   task automatic run_read(input logic [15:0] addr, input bit burst,
                           input bit qwr, input logic [15:0] qaddr, input logic [15:0] qdata);
      int widx, base, nb, beat;
      bit exp_v, exp_busy;
      logic [15:0] last_d;
      widx = word_of(addr);
      base = burst ? widx - (widx % BL) : widx;
      nb   = burst ? BL : 1;
      beat = 0;
      last_d = '0;
      req_valid = 1'b1; req_wr = 1'b0; req_burst = burst; req_addr = addr;
      req_wdata = 16'($urandom);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL rd_ready: got %b want 1", req_ready); end
      tick;
      if (qwr) begin
         req_wr = 1'b1; req_addr = qaddr; req_wdata = qdata;
      end else begin
         req_valid = 1'b0;
      end
      for (int j = 0; j <= LAT - 1 + nb + 1; j++) begin
         if (j > 0) tick;
         exp_v    = (j >= LAT - 1) && (j < LAT - 1 + nb);
         exp_busy = (j < LAT - 1 + nb);
         total++;
         if (rsp_valid !== exp_v) begin
            bad++; $display("FAIL rsp_valid j=%0d: got %b want %b", j, rsp_valid, exp_v);
         end
         total++;
         if (busy !== exp_busy || req_ready !== !exp_busy) begin
            bad++; $display("FAIL busy_ready j=%0d: got %b/%b want %b/%b", j, busy, req_ready, exp_busy, !exp_busy);
         end
         total++;
         if (rsp_last !== (exp_v && beat == nb - 1)) begin
            bad++; $display("FAIL rsp_last j=%0d: got %b want %b", j, rsp_last, exp_v && beat == nb - 1);
         end
         if (exp_v) begin
            total++;
            if (rsp_data !== mem_m[base + beat]) begin
               bad++; $display("FAIL rsp_data beat=%0d: got %h want %h", beat, rsp_data, mem_m[base + beat]);
            end
            last_d = mem_m[base + beat];
            beat++;
         end else if (j > LAT - 1) begin
            total++;
            if (rsp_data !== last_d) begin
               bad++; $display("FAIL rsp_hold j=%0d: got %h want %h", j, rsp_data, last_d);
            end
         end
      end
      req_valid = 1'b0; req_wr = 1'b0;
      if (qwr) mem_m[word_of(qaddr)] = qdata;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #20;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_last !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_vals: ready=%b valid=%b data=%h last=%b busy=%b want 1 0 0000 0 0",
                  req_ready, rsp_valid, rsp_data, rsp_last, busy);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick;
   endtask

   task automatic test_single;
      do_write(16'h0010, 16'hBEEF);
      run_read(16'h0010, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_burst;
      for (int i = 0; i < 8; i++) do_write(16'(16'h0020 + 2 * i), 16'(16'h1000 + i));
      run_read(16'h0026, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic test_reset_mid_wait;
      do_write(16'h0040, 16'h5A5A);
      req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b0; req_addr = 16'h0040;
      tick;
      req_valid = 1'b0;
      tick;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_last !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_wait: ready=%b valid=%b data=%h last=%b busy=%b want 1 0 0000 0 0",
                  req_ready, rsp_valid, rsp_data, rsp_last, busy);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int j = 0; j < LAT + 8; j++) begin
         tick;
         total++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL post_rst j=%0d: valid=%b ready=%b want 0 1", j, rsp_valid, req_ready);
         end
      end
   endtask

   task automatic test_held_valid;
      for (int i = 0; i < 8; i++) do_write(16'(16'h0200 + 2 * i), 16'(16'h1111 + i));
      run_read(16'h0204, 1'b1, 1'b1, 16'h0200, 16'h2222);
      run_read(16'h0200, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_alias;
      do_write(16'h07FE, 16'hA5A5);
      run_read(16'h0FFE, 1'b0, 1'b0, '0, '0);
      run_read(16'h0FFF, 1'b0, 1'b0, '0, '0);
      do_write(16'h0FFF, 16'h3C3C);
      run_read(16'h07FE, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         int blk;
         blk = $urandom_range(0, DEPTH / BL - 1) * BL;
         for (int i = 0; i < BL; i++)
            do_write(16'((blk + i + DEPTH * $urandom_range(0, 31)) * 2 + $urandom_range(0, 1)), 16'($urandom));
         run_read(16'((blk + $urandom_range(0, BL - 1)) * 2 + $urandom_range(0, 1)), 1'b1, 1'b0, '0, '0);
         run_read(16'((blk + $urandom_range(0, BL - 1)) * 2), 1'b0, 1'b0, '0, '0);
      end
   endtask

   task automatic test_latency1;
      l1_valid = 1'b1; l1_wr = 1'b1; l1_addr = 16'h0100; l1_wdata = 16'h1234;
      tick;
      l1_wr = 1'b0; l1_burst = 1'b0; l1_addr = 16'h0101;
      total++;
      if (l1_ready !== 1'b1) begin bad++; $display("FAIL l1_ready: got %b want 1", l1_ready); end
      tick;
      l1_valid = 1'b0;
      total++;
      if (l1_rvalid !== 1'b1 || l1_rlast !== 1'b1 || l1_busy !== 1'b1 || l1_ready !== 1'b0) begin
         bad++; $display("FAIL l1_beat_ctl: valid=%b last=%b busy=%b ready=%b want 1 1 1 0",
                         l1_rvalid, l1_rlast, l1_busy, l1_ready);
      end
      total++;
      if (l1_rdata !== 16'h1234) begin bad++; $display("FAIL l1_data: got %h want 1234", l1_rdata); end
      tick;
      total++;
      if (l1_rvalid !== 1'b0 || l1_ready !== 1'b1 || l1_rdata !== 16'h1234) begin
         bad++; $display("FAIL l1_after: valid=%b ready=%b data=%h want 0 1 1234", l1_rvalid, l1_ready, l1_rdata);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_burst;
      test_reset_mid_wait;
      test_held_valid;
      test_alias;
      test_random;
      test_latency1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
